// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 encodings, responder FSM states and the captured request record.
package mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_align.sv
// Lane steering for the data-memory responder: byte enables and lane-replicated
// write data for stores, lane extraction and sign/zero extension for loads, and
// detection of misaligned or unsupported funct3 encodings.
module mem_align
    import mem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        bad
);

    logic [31:0] shifted_s;

    // Addressed byte/half moved down to bit 0 for extraction.
    assign shifted_s = rword >> {addr_lo, 3'b000};

    // Decode the access size into enables, write data, load data and legality.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = wdata;
        ld_data = 32'h0000_0000;
        bad     = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    byte_en = 4'b0001 << addr_lo;
                    wr_word = {4{wdata[7:0]}};
                end
                F3_H: begin
                    wr_word = {2{wdata[15:0]}};
                    if (addr_lo[0]) begin
                        bad = 1'b1;
                    end else begin
                        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
                    end
                end
                F3_W: begin
                    if (addr_lo != 2'b00) begin
                        bad = 1'b1;
                    end else begin
                        byte_en = 4'b1111;
                    end
                end
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                F3_BU: ld_data = {24'h00_0000, shifted_s[7:0]};
                F3_H: begin
                    if (addr_lo[0]) begin
                        bad = 1'b1;
                    end else begin
                        ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                    end
                end
                F3_HU: begin
                    if (addr_lo[0]) begin
                        bad = 1'b1;
                    end else begin
                        ld_data = {16'h0000, shifted_s[15:0]};
                    end
                end
                F3_W: begin
                    if (addr_lo != 2'b00) begin
                        bad = 1'b1;
                    end else begin
                        ld_data = rword;
                    end
                end
                default: bad = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access on an internal word array and returns a
// registered response. DEPTH must be a power of two, at least 2.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RESP_VALID,
    input  logic        RESP_READY,
    output logic [31:0] RESP_RDATA,
    output logic        RESP_ERR
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state_r;
    state_t           next_state_s;
    mem_req_t         req_r;
    logic [3:0]       cnt_r;
    logic [31:0]      mem_r [DEPTH];
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      word_s;
    logic [3:0]       be_s;
    logic [31:0]      wword_s;
    logic [31:0]      ldata_s;
    logic             align_err_s;
    logic             range_err_s;
    logic             err_s;
    logic             access_s;
    logic             resp_valid_r;
    logic [31:0]      resp_rdata_r;
    logic             resp_err_r;

    assign idx_s       = req_r.addr[IDX_W+1:2];
    assign range_err_s = (req_r.addr[31:2] >= 30'(DEPTH));
    assign word_s      = mem_r[idx_s];
    assign err_s       = range_err_s | align_err_s;
    assign access_s    = (state_r == S_WAIT) && (cnt_r == 4'd0);

    assign REQ_READY  = (state_r == S_IDLE);
    assign RESP_VALID = resp_valid_r;
    assign RESP_RDATA = resp_rdata_r;
    assign RESP_ERR   = resp_err_r;

    mem_align u_align (
        .we      (req_r.we),
        .funct3  (req_r.funct3),
        .addr_lo (req_r.addr[1:0]),
        .rword   (word_s),
        .wdata   (req_r.wdata),
        .byte_en (be_s),
        .wr_word (wword_s),
        .ld_data (ldata_s),
        .bad     (align_err_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (REQ_VALID) begin
                    next_state_s = S_WAIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (access_s) begin
                    next_state_s = S_RESP;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_RESP: begin
                if (RESP_READY) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Request capture on acceptance and wait-counter countdown.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_r <= '0;
            cnt_r <= 4'd0;
        end else if ((state_r == S_IDLE) && REQ_VALID) begin
            req_r <= '{we: REQ_WE, funct3: REQ_FUNCT3, addr: REQ_ADDR, wdata: REQ_WDATA};
            cnt_r <= 4'(LATENCY);
        end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response registers: loaded on the access edge, valid dropped on handshake.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else if (access_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= err_s;
            resp_rdata_r <= (err_s || req_r.we) ? 32'h0000_0000 : ldata_s;
        end else if ((state_r == S_RESP) && RESP_READY) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Byte-lane writes into the (unreset) memory array on a legal store.
    always_ff @(posedge CLK) begin
        if (access_s && req_r.we && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=3, DEPTH=1024).
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [2:0]  REQ_FUNCT3 = 3'b000;
    logic [31:0] REQ_ADDR = 32'h0;
    logic [31:0] REQ_WDATA = 32'h0;
    logic        RESP_VALID;
    logic        RESP_READY = 1'b0;
    logic [31:0] RESP_RDATA;
    logic        RESP_ERR;

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(.DEPTH(1024), .LATENCY(3)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
        .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction with RESP_READY held high; called #1 after a rising edge.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic to;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (REQ_READY) break;
            @(posedge CLK); #1;
        end
        REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
        REQ_VALID = 1'b1; RESP_READY = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (RESP_VALID) begin
                to = 1'b0;
                break;
            end
            @(posedge CLK); #1;
        end
        chk("resp_timeout", {31'd0, to}, 32'd0);
        rd = RESP_RDATA;
        er = RESP_ERR;
        @(posedge CLK); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    logic        seen;

    initial begin
        // Reset state, with a request presented during reset.
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h20; REQ_WDATA = 32'h77;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_resp_valid", {31'd0, RESP_VALID}, 32'd0);
        chk("rst_resp_rdata", RESP_RDATA, 32'd0);
        chk("rst_resp_err", {31'd0, RESP_ERR}, 32'd0);
        chk("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
        REQ_VALID = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Word store / load.
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", {31'd0, er}, 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);

        // Sub-word loads.
        xact(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
        chk("lb_13", rd, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'h0, rd, er);
        chk("lbu_13", rd, 32'h000000DE);
        xact(1'b0, 3'b001, 32'h12, 32'h0, rd, er);
        chk("lh_12", rd, 32'hFFFFDEAD);
        xact(1'b0, 3'b101, 32'h10, 32'h0, rd, er);
        chk("lhu_10", rd, 32'h0000BEEF);

        // Sub-word stores.
        xact(1'b1, 3'b000, 32'h11, 32'h000000AA, rd, er);
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("lw_after_sb", rd, 32'hDEADAAEF);
        xact(1'b0, 3'b000, 32'h11, 32'h0, rd, er);
        chk("lb_11", rd, 32'hFFFFFFAA);
        xact(1'b1, 3'b001, 32'h12, 32'h00001234, rd, er);
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("lw_after_sh", rd, 32'h1234AAEF);

        // Illegal requests.
        xact(1'b1, 3'b001, 32'h11, 32'h0000FFFF, rd, er);
        chk("sh_mis_err", {31'd0, er}, 32'd1);
        chk("sh_mis_rdata", rd, 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
        chk("lw_after_bad_sh", rd, 32'h1234AAEF);
        xact(1'b0, 3'b010, 32'd4096, 32'h0, rd, er);
        chk("lw_range_err", {31'd0, er}, 32'd1);
        chk("lw_range_rdata", rd, 32'd0);
        xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
        chk("ld_f3_011_err", {31'd0, er}, 32'd1);
        chk("ld_f3_011_rdata", rd, 32'd0);
        xact(1'b1, 3'b100, 32'h10, 32'h0, rd, er);
        chk("st_f3_100_err", {31'd0, er}, 32'd1);
        xact(1'b0, 3'b010, 32'h12, 32'h0, rd, er);
        chk("lw_mis_err", {31'd0, er}, 32'd1);

        // Latency and backpressure: accept at edge 0, valid after edge 4.
        REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h10;
        REQ_VALID = 1'b1; RESP_READY = 1'b0;
        chk("lat_ready_idle", {31'd0, REQ_READY}, 32'd1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("lat_ready_busy", {31'd0, REQ_READY}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            chk("lat_valid_early", {31'd0, RESP_VALID}, 32'd0);
        end
        @(posedge CLK); #1;
        chk("lat_valid_edge4", {31'd0, RESP_VALID}, 32'd1);
        chk("lat_rdata", RESP_RDATA, 32'h1234AAEF);
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            chk("hold_valid", {31'd0, RESP_VALID}, 32'd1);
            chk("hold_rdata", RESP_RDATA, 32'h1234AAEF);
            chk("hold_req_ready", {31'd0, REQ_READY}, 32'd0);
        end
        RESP_READY = 1'b1;
        @(posedge CLK); #1;
        chk("hs_valid_low", {31'd0, RESP_VALID}, 32'd0);
        chk("hs_req_ready", {31'd0, REQ_READY}, 32'd1);

        // Reset in flight: prior contents at 0x20, then abort an SW in S_WAIT.
        xact(1'b1, 3'b010, 32'h20, 32'h11223344, rd, er);
        xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
        chk("lw_20_prior", rd, 32'h11223344);
        REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h20; REQ_WDATA = 32'h55;
        REQ_VALID = 1'b1; RESP_READY = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("abort_resp_valid", {31'd0, RESP_VALID}, 32'd0);
        chk("abort_resp_rdata", RESP_RDATA, 32'd0);
        chk("abort_resp_err", {31'd0, RESP_ERR}, 32'd0);
        chk("abort_req_ready", {31'd0, REQ_READY}, 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK); #1;
            if (RESP_VALID) seen = 1'b1;
        end
        chk("abort_no_resp", {31'd0, seen}, 32'd0);
        xact(1'b0, 3'b010, 32'h20, 32'h0, rd, er);
        chk("lw_20_after_abort", rd, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
